// File: rtl/sphn_pong_game_ctrl.sv
// Game-flow controller for the VGA pong core.
// Sequences idle/serve/play/over on the frame tick, owns the player paddle
// position and both scores, and gates the ball datapath.
// Optional build macro: SPHN_PONG_SPEEDUP_EN (paddle-hit driven ball speed-up).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | power-up, waiting for start; ball held, paddle movable
// SERVE | countdown of SERVE_FRAMES ticks with ball held at centre
// PLAY  | ball stepping once per frame; misses score points
// OVER  | a player reached WIN_SCORE; paddle frozen, waiting for start
module sphn_pong_game_ctrl #(
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_STEP  = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       pix_clk,
    input  logic       pix_rst,
    input  logic       i_frame_tick,
    input  logic       i_move_up,
    input  logic       i_move_down,
    input  logic       i_start,
    input  logic       i_miss_left,
    input  logic       i_miss_right,
    input  logic       i_paddle_hit,
    output logic [8:0] o_paddle_y,
    output logic       o_ball_step,
    output logic       o_ball_hold,
    output logic       o_serve_dir,
    output logic [3:0] o_score_l,
    output logic [3:0] o_score_r,
    output logic [1:0] o_state,
    output logic       o_winner,
    output logic [1:0] o_ball_speed
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam int               CNT_W    = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam int               Y_MAX_I  = SCREEN_H - PADDLE_H;
    localparam logic [8:0]       Y_MAX    = 9'(Y_MAX_I);
    localparam logic [8:0]       Y_RST    = 9'(Y_MAX_I / 2);
    localparam logic [8:0]       Y_STEP   = 9'(PADDLE_STEP);
    localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

    logic             up_s1, up_s2;
    logic             dn_s1, dn_s2;
    logic             st_s1, st_s2, st_prev;
    logic             start_evt;

    logic [CNT_W-1:0] serve_cnt, serve_cnt_nxt;
    logic [1:0]       state_nxt;
    logic [3:0]       score_l_nxt, score_r_nxt;
    logic [3:0]       score_l_inc, score_r_inc;
    logic             serve_dir_nxt, winner_nxt;

    logic [8:0]       y_up, y_dn, paddle_nxt;
    logic             any_miss;

    assign start_evt   = st_s2 & ~st_prev;
    assign any_miss    = i_miss_left | i_miss_right;
    assign score_l_inc = o_score_l + 4'd1;
    assign score_r_inc = o_score_r + 4'd1;

    // Two-flop synchronizers for the buttons, plus the start edge history.
    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            up_s1   <= 1'b0;
            up_s2   <= 1'b0;
            dn_s1   <= 1'b0;
            dn_s2   <= 1'b0;
            st_s1   <= 1'b0;
            st_s2   <= 1'b0;
            st_prev <= 1'b0;
        end else begin
            up_s1   <= i_move_up;
            up_s2   <= up_s1;
            dn_s1   <= i_move_down;
            dn_s2   <= dn_s1;
            st_s1   <= i_start;
            st_s2   <= st_s1;
            st_prev <= st_s2;
        end
    end

    // Saturating paddle moves; limits are checked before the add/subtract so nothing wraps.
    always_comb begin
        y_up = (o_paddle_y >= Y_STEP) ? (o_paddle_y - Y_STEP) : 9'd0;
        y_dn = ((int'(o_paddle_y) + PADDLE_STEP) > Y_MAX_I) ? Y_MAX : (o_paddle_y + Y_STEP);
        paddle_nxt = o_paddle_y;
        if (i_frame_tick && (o_state != ST_OVER)) begin
            case ({up_s2, dn_s2})
                2'b10:   paddle_nxt = y_up;
                2'b01:   paddle_nxt = y_dn;
                default: paddle_nxt = o_paddle_y;
            endcase
        end
    end

    // Game FSM next-state: serve countdown, scoring and winner detection.
    always_comb begin
        state_nxt     = o_state;
        serve_cnt_nxt = serve_cnt;
        score_l_nxt   = o_score_l;
        score_r_nxt   = o_score_r;
        serve_dir_nxt = o_serve_dir;
        winner_nxt    = o_winner;
        case (o_state)
            ST_IDLE, ST_OVER: begin
                if (start_evt) begin
                    state_nxt     = ST_SERVE;
                    serve_cnt_nxt = CNT_LOAD;
                    score_l_nxt   = 4'd0;
                    score_r_nxt   = 4'd0;
                    serve_dir_nxt = 1'b0;
                    winner_nxt    = 1'b0;
                end
            end
            ST_SERVE: begin
                if (i_frame_tick) begin
                    if (serve_cnt <= CNT_ONE) begin
                        state_nxt     = ST_PLAY;
                        serve_cnt_nxt = '0;
                    end else begin
                        serve_cnt_nxt = serve_cnt - CNT_ONE;
                    end
                end
            end
            ST_PLAY: begin
                // Left miss has priority; a simultaneous right miss is dropped.
                if (i_miss_left) begin
                    score_r_nxt   = score_r_inc;
                    serve_dir_nxt = 1'b0;
                    if (score_r_inc == WIN) begin
                        state_nxt  = ST_OVER;
                        winner_nxt = 1'b1;
                    end else begin
                        state_nxt     = ST_SERVE;
                        serve_cnt_nxt = CNT_LOAD;
                    end
                end else if (i_miss_right) begin
                    score_l_nxt   = score_l_inc;
                    serve_dir_nxt = 1'b1;
                    if (score_l_inc == WIN) begin
                        state_nxt  = ST_OVER;
                        winner_nxt = 1'b0;
                    end else begin
                        state_nxt     = ST_SERVE;
                        serve_cnt_nxt = CNT_LOAD;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Register game state and all ball-control outputs.
    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            o_state     <= ST_IDLE;
            serve_cnt   <= '0;
            o_score_l   <= 4'd0;
            o_score_r   <= 4'd0;
            o_serve_dir <= 1'b0;
            o_winner    <= 1'b0;
            o_paddle_y  <= Y_RST;
            o_ball_step <= 1'b0;
            o_ball_hold <= 1'b1;
        end else begin
            o_state     <= state_nxt;
            serve_cnt   <= serve_cnt_nxt;
            o_score_l   <= score_l_nxt;
            o_score_r   <= score_r_nxt;
            o_serve_dir <= serve_dir_nxt;
            o_winner    <= winner_nxt;
            o_paddle_y  <= paddle_nxt;
            o_ball_step <= (o_state == ST_PLAY) && i_frame_tick && !any_miss;
            o_ball_hold <= (state_nxt != ST_PLAY);
        end
    end

`ifdef SPHN_PONG_SPEEDUP_EN
    logic [1:0] hit_cnt;
    logic       serve_entry;

    assign serve_entry = (state_nxt == ST_SERVE) && (o_state != ST_SERVE);

    // Every fourth paddle hit raises the ball speed by one level, up to 3.
    always_ff @(posedge pix_clk) begin
        if (pix_rst || serve_entry) begin
            hit_cnt      <= 2'd0;
            o_ball_speed <= 2'd0;
        end else if ((o_state == ST_PLAY) && i_paddle_hit) begin
            hit_cnt <= hit_cnt + 2'd1;
            if ((hit_cnt == 2'd3) && (o_ball_speed != 2'd3)) begin
                o_ball_speed <= o_ball_speed + 2'd1;
            end
        end
    end
`else
    logic unused_paddle_hit;

    assign unused_paddle_hit = i_paddle_hit;
    assign o_ball_speed      = 2'd0;
`endif

endmodule
